// File: rtl/seq_multiplier_if.sv
// ----------------------------------------------------------------------------
// seq_multiplier_if
// Operand/result bundle for the sequential shift-add multiplier.
//   a   : multiplicand (WIDTH bits), driven by the master
//   b   : multiplier   (WIDTH bits), driven by the master
//   p   : product      (2*WIDTH bits), driven by the slave, valid when rdy=1
//   rdy : high when p holds the final product
// Modports: master (software/bench side), slave (multiplier side).
// ----------------------------------------------------------------------------
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2*WIDTH-1:0] p;
  logic               rdy;

  modport master (output a, output b, input p, input rdy);
  modport slave  (input a, input b, output p, output rdy);
endinterface

// File: rtl/seq_multiplier.sv
// ----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier: one multiplier bit per clock, LSB first.
// Operands are captured on the first rising edge after reset is released,
// WIDTH further edges accumulate, and the product plus rdy are registered on
// the last of them (edge WIDTH+1 after release). p reads 0 until then.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset; a new operation starts on release
//   bus   : seq_multiplier_if.slave carrying a, b (in) and p, rdy (out)
//
// Optional build macro: SEQ_MULT_SIGNED_EN
//   defined   -> two's-complement operands; magnitudes are multiplied and the
//                result is negated at the DONE transition if signs differ.
//   undefined -> unsigned operands, no sign logic.
// ----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  seq_multiplier_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {LOAD, BUSY, DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand;   // multiplicand, pre-shifted by the bit index
  logic [WIDTH-1:0]   r_mplier;  // multiplier, shifted right so bit 0 is current
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_p;
  logic               r_rdy;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH-1:0] w_acc_sum;
  logic [2*WIDTH-1:0] w_result;

`ifdef SEQ_MULT_SIGNED_EN
  logic r_neg;

  // The most-negative value negates to itself, which is still the correct
  // magnitude when read as unsigned.
  assign w_a_mag  = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag  = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
  assign w_result = r_neg ? (~w_acc_sum + 1'b1) : w_acc_sum;
`else
  assign w_a_mag  = bus.a;
  assign w_b_mag  = bus.b;
  assign w_result = w_acc_sum;
`endif

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  // Includes the current bit, so the final edge can register the full product.
  assign w_acc_sum = r_acc + w_addend;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_p      <= '0;
      r_rdy    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        LOAD: begin
          r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
          r_mplier <= w_b_mag;
          r_acc    <= '0;
          r_cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
          r_neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
          r_state  <= BUSY;
        end
        BUSY: begin
          r_acc    <= w_acc_sum;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_p     <= w_result;
            r_rdy   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          // Result held until the next reset.
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign bus.p   = r_p;
  assign bus.rdy = r_rdy;

endmodule

// File: tb/tb_seq_multiplier.sv
// ----------------------------------------------------------------------------
// tb_seq_multiplier
// Directed bench for seq_multiplier (WIDTH=32). Each step resets the block
// with the operands applied, releases reset on a falling edge, then checks
// rdy/p after every rising edge up to and including edge 33.
// Build with +define+SEQ_MULT_SIGNED_EN to select the signed expectations.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  seq_multiplier_if #(.WIDTH(WIDTH)) bus ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Hold reset with operands applied, check reset outputs, release on negedge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    reset = 1'b0;
    bus.a = a;
    bus.b = b;
    repeat (2) @(negedge clk);
    check("reset_p",   bus.p, 64'd0);
    check("reset_rdy", {63'd0, bus.rdy}, 64'd0);
    reset = 1'b1;
  endtask

  // Edges 1..n after release: rdy and p must both still read 0.
  task automatic run_busy(input int n, input string tag);
    for (int e = 1; e <= n; e++) begin
      @(posedge clk); #1;
      check({tag, "_busy_rdy"}, {63'd0, bus.rdy}, 64'd0);
      check({tag, "_busy_p"},   bus.p, 64'd0);
    end
  endtask

  // Edge 33: product and rdy appear.
  task automatic finish_op(input string tag, input logic [63:0] exp);
    @(posedge clk); #1;
    check({tag, "_rdy"}, {63'd0, bus.rdy}, 64'd1);
    check({tag, "_p"},   bus.p, exp);
    $display("op %s: a=0x%08h b=0x%08h p=0x%016h rdy=%0d expected=0x%016h",
             tag, bus.a, bus.b, bus.p, bus.rdy, exp);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    #1;
    check("async_reset_p", bus.p, 64'd0);

    // Basic 3 x 5, then 10 cycles of stable output.
    start_op(32'd3, 32'd5);
    run_busy(32, "basic");
    finish_op("basic", 64'h0000_0000_0000_000F);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("basic_hold_p",   bus.p, 64'h0000_0000_0000_000F);
      check("basic_hold_rdy", {63'd0, bus.rdy}, 64'd1);
    end

    // All-ones operands.
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_busy(32, "max");
`ifdef SEQ_MULT_SIGNED_EN
    finish_op("max", 64'h0000_0000_0000_0001);
`else
    finish_op("max", 64'hFFFF_FFFE_0000_0001);
`endif

    // Operand change after the capture edge is ignored.
    start_op(32'd7, 32'd6);
    run_busy(2, "hold");
    bus.a = 32'h1234_5678;
    run_busy(30, "hold");
    finish_op("hold", 64'h0000_0000_0000_002A);

    // Reset mid-operation, between edge 15 and 16.
    start_op(32'd10, 32'd10);
    run_busy(15, "midrst");
    #2;
    reset = 1'b0;
    #1;
    check("midrst_async_p",   bus.p, 64'd0);
    check("midrst_async_rdy", {63'd0, bus.rdy}, 64'd0);
    start_op(32'd4, 32'd9);
    run_busy(32, "midrst");
    finish_op("midrst", 64'h0000_0000_0000_0024);

    // Zero multiplicand still takes the full latency.
    start_op(32'd0, 32'hDEAD_BEEF);
    run_busy(32, "zero");
    finish_op("zero", 64'd0);

    // Sign-dependent case.
    start_op(32'hFFFF_FFFD, 32'd5);
    run_busy(32, "sign");
`ifdef SEQ_MULT_SIGNED_EN
    finish_op("sign", 64'hFFFF_FFFF_FFFF_FFF1);
`else
    finish_op("sign", 64'h0000_0004_FFFF_FFF1);
`endif

    // Most-negative squared (same bit pattern in both modes).
    start_op(32'h8000_0000, 32'h8000_0000);
    run_busy(32, "minneg");
    finish_op("minneg", 64'h4000_0000_0000_0000);

    // Mixed pattern.
    start_op(32'h1234_5678, 32'h0000_0100);
    run_busy(32, "mixed");
    finish_op("mixed", 64'h0000_0012_3456_7800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
